instruction_fetch_queue: RTL and testbench
==========================================

# instruction_fetch_queue

Decoupled fetch stage sitting between a variable-latency instruction memory port and the IF/ID pipeline register. It owns the fetch PC and issues one outstanding request at a time with a req/ack handshake. Fetched instructions are buffered in a small FIFO together with their PC+1. IF/ID pops the head entry, and the jump controller redirects fetch by flushing the queue and loading a new PC.

## Interface
Parameters:
- `INSTR_LEN`, default 19: instruction width.
- `ADDR_LEN`, default 12: PC / instruction address width.
- `DEPTH`, default 4: FIFO entries; a power of two, at least 2.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `imem_req`  out  1  request outstanding to instruction memory.
- `imem_addr`  out  ADDR_LEN  fetch address; stable while `imem_req`=1 until the ack edge.
- `imem_ack`  in  1  memory returns `imem_data` this cycle; ignored when `imem_req`=0.
- `imem_data`  in  INSTR_LEN  instruction word, valid with `imem_ack`.
- `redirect`  in  1  taken jump, call, return or branch; flush the queue and refetch.
- `redirect_pc`  in  ADDR_LEN  new fetch PC, sampled when `redirect`=1.
- `deq`  in  1  IF/ID consumes the head entry (IF/ID write enable).
- `valid`  out  1  FIFO non-empty.
- `instruction`  out  INSTR_LEN  head instruction; 0 when empty.
- `pc_plus1`  out  ADDR_LEN  head PC+1; 0 when empty.
- `count`  out  $clog2(DEPTH)+1  occupancy.

## Operation
- State machine states:
  - IDLE: no request outstanding.
  - WAIT: request outstanding; data will be kept.
  - DISCARD: request outstanding; returning data will be dropped.
- `imem_req` = (state != IDLE). `imem_addr` = `fetch_pc`.
- IDLE transitions:
  - `redirect`: `fetch_pc`<=`redirect_pc`, flush, stay IDLE.
  - Otherwise, if `count` < DEPTH: go to WAIT.
- WAIT transitions:
  - `redirect` (with or without `imem_ack`): flush, `fetch_pc`<=`redirect_pc`. Go to IDLE if `imem_ack`=1, else go to DISCARD.
  - `imem_ack` without redirect: enqueue {`imem_data`, `fetch_pc`+1} and set `fetch_pc`<=`fetch_pc`+1. Stay in WAIT if (count + 1 − deq_eff) < DEPTH, else go to IDLE.
- DISCARD transitions:
  - `redirect`: update `fetch_pc`, stay DISCARD.
  - `imem_ack`: drop the data, go to IDLE.
- `deq_eff` = `deq` & `valid` & ~`redirect`. `deq` while empty is ignored.
- Simultaneous enqueue and dequeue: occupancy is unchanged and both pointers advance.
- PC arithmetic is modulo 2^ADDR_LEN: `fetch_pc` 0xFFF increments to 0x000, and `pc_plus1` for the instruction at 0xFFF is 0x000.
- Redirect always overrides deq and enqueue in the same cycle.
- Enqueue while full cannot occur by construction; the bench asserts this.

## Timing
- Reset values:
  - state IDLE, `fetch_pc` 0, head/tail pointers 0.
  - `count` 0, `valid` 0, `imem_req` 0.
  - `instruction` 0, `pc_plus1` 0.
- Reset asserted mid-request: the request is abandoned immediately. The memory must tolerate `imem_req` dropping without an ack.
- First rising edge after reset release: IDLE→WAIT, so `imem_req`=1 in cycle 1.
- Zero-wait memory (`imem_ack` = `imem_req`): first `valid` after edge 2, then sustained 1 instruction/cycle while IF/ID dequeues each cycle.
- Redirect in cycle N with a zero-wait memory:
  - From WAIT with ack in cycle N: queue empty after edge N+1, state IDLE, request for `redirect_pc` in cycle N+2, first new `valid` after edge N+3.
  - From DISCARD: a delay of k cycles until ack adds k cycles.
- Outputs `valid`, `instruction`, `pc_plus1` and `count` are pure functions of registered state; there is no combinational path from `deq`.

## Structure
- Widths come from the existing `defines.sv` constants (`INSTRUCTION_LEN`, `ADDRESS_LEN`).
- Package `ifq_pkg` holds:
  - the state enum `ifq_state_e` {IDLE, WAIT, DISCARD};
  - the entry struct `ifq_entry_t` {instruction, pc_plus1}.
- Sub-module `ifq_fifo`:
  - a DEPTH-entry circular buffer of `ifq_entry_t`;
  - ports: push, pop, flush, head entry, count;
  - pointer wrap via $clog2(DEPTH)-bit indices;
  - flush has priority over push and pop.
- The top-level file contains the FSM and fetch-PC logic.

## Test plan
- Zero-wait memory, `deq`=1 always, ROM word = address: after reset, `valid` rises after edge 2, then `pc_plus1` = 1, 2, 3… on consecutive cycles and `instruction` = 0, 1, 2….
- `deq`=0: memory acks 4 times, `count`=4, `imem_req` drops to 0. Assert `deq` for 1 cycle: `count`=3, then a new request is issued the next cycle.
- Memory with 3-cycle latency: assert `redirect`=1 with `redirect_pc`=0x200 in the 2nd wait cycle. State goes to DISCARD, the ack data is not enqueued, and the next `imem_addr`=0x200 with first entry `pc_plus1`=0x201.
- `fetch_pc` preset to 0xFFE via redirect: entries show `pc_plus1` 0xFFF, then 0x000, then 0x001 (wrap-around).
- Same cycle as ack: `redirect`=1 and `deq`=1 with `count`=2. After the edge, `count`=0 and the acked data is dropped.
- `rst` pulsed asynchronously (between edges) while in WAIT with `count`=3: all outputs return to reset values immediately, and fetching restarts from PC 0.

Source files
------------

// File: rtl/ifq_pkg.sv
// Shared types for the instruction fetch queue.
//   INSTRUCTION_LEN / ADDRESS_LEN : core-wide instruction and address widths
//                                   (same values as the core defines).
//   ifq_state_e                   : fetch FSM state.
//   ifq_entry_t                   : one buffered fetch result.
package ifq_pkg;

  localparam int INSTRUCTION_LEN = 19;
  localparam int ADDRESS_LEN     = 12;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,  // no request outstanding
    WAIT    = 2'd1,  // request outstanding, returned data is kept
    DISCARD = 2'd2   // request outstanding, returned data is dropped
  } ifq_state_e;

  typedef struct packed {
    logic [INSTRUCTION_LEN-1:0] instruction;
    logic [ADDRESS_LEN-1:0]     pc_plus1;
  } ifq_entry_t;

  localparam int ENTRY_W = $bits(ifq_entry_t);

endpackage

// File: rtl/instruction_fetch_queue_fifo.sv
// ifq_fifo: DEPTH-entry circular buffer of ifq_entry_t.
//   clk, rst    : clock, asynchronous active-high reset
//   push        : write push_entry at the tail
//   pop         : drop the head entry (ignored while empty)
//   flush       : empty the buffer; wins over push and pop
//   push_entry  : entry to write
//   head_entry  : entry at the head (contents undefined while count is 0)
//   count       : occupancy, 0..DEPTH
module ifq_fifo
  import ifq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [ENTRY_W-1:0]       push_entry,
  output logic [ENTRY_W-1:0]       head_entry,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  ifq_entry_t       mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign do_push = push & ~flush;
  assign do_pop  = pop & ~flush & (count_q != '0);

  // DEPTH is a power of two, so pointers wrap by plain overflow.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the head is only observed while count is non-zero.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_entry;
  end

  assign head_entry = mem_q[rd_ptr_q];
  assign count      = count_q;

endmodule

// File: rtl/instruction_fetch_queue.sv
// instruction_fetch_queue: decoupled fetch stage between a variable-latency
// instruction memory and the IF/ID register. Owns the fetch PC, keeps one
// memory request outstanding at a time and buffers results with their PC+1.
//   clk, rst            : clock, asynchronous active-high reset
//   imem_req/imem_addr  : request to instruction memory
//   imem_ack/imem_data  : memory response
//   redirect/redirect_pc: flush the queue and restart fetch at redirect_pc
//   deq                 : IF/ID consumes the head entry
//   valid/instruction/pc_plus1/count : head entry and occupancy (0 when empty)
//   dbg_state           : current FSM state (ifq_state_e encoding)
//
// Memory handshake: imem_req=1 with imem_addr held stable means one request
// is outstanding; the request completes on the rising edge where imem_ack=1,
// and imem_data is taken on that same edge. imem_ack is ignored while
// imem_req=0. A new request may start in the cycle right after the ack edge.
// The request may be withdrawn without an ack only by reset.
//
// Widths are sized through ifq_pkg; INSTR_LEN/ADDR_LEN must equal the
// package constants.
module instruction_fetch_queue
  import ifq_pkg::*;
#(
  parameter int INSTR_LEN = INSTRUCTION_LEN,
  parameter int ADDR_LEN  = ADDRESS_LEN,
  parameter int DEPTH     = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   imem_req,
  output logic [ADDR_LEN-1:0]    imem_addr,
  input  logic                   imem_ack,
  input  logic [INSTR_LEN-1:0]   imem_data,
  input  logic                   redirect,
  input  logic [ADDR_LEN-1:0]    redirect_pc,
  input  logic                   deq,
  output logic                   valid,
  output logic [INSTR_LEN-1:0]   instruction,
  output logic [ADDR_LEN-1:0]    pc_plus1,
  output logic [$clog2(DEPTH):0] count,
  output logic [1:0]             dbg_state
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  ifq_state_e          state_q, state_d;
  logic [ADDR_LEN-1:0] fetch_pc_q, fetch_pc_d;
  logic                push;
  logic                deq_eff;
  logic                fifo_valid;
  logic [CNT_W-1:0]    fifo_count;
  logic [CNT_W:0]      next_occ;
  ifq_entry_t          push_entry;
  ifq_entry_t          head_entry;

  assign fifo_valid = (fifo_count != '0);
  // A redirect discards the queue, so a simultaneous dequeue is meaningless.
  assign deq_eff    = deq & fifo_valid & ~redirect;
  // Occupancy after this edge if the pending ack is enqueued.
  assign next_occ   = (CNT_W+1)'(fifo_count) + (CNT_W+1)'(1) - (CNT_W+1)'(deq_eff);

  assign push_entry.instruction = imem_data;
  assign push_entry.pc_plus1    = fetch_pc_q + ADDR_LEN'(1);

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    push       = 1'b0;
    if (redirect) fetch_pc_d = redirect_pc;
    case (state_q)
      IDLE: begin
        if (!redirect && (fifo_count < CNT_W'(DEPTH))) state_d = WAIT;
      end
      WAIT: begin
        if (redirect) begin
          // The in-flight request still has to be drained unless it completes now.
          state_d = imem_ack ? IDLE : DISCARD;
        end else if (imem_ack) begin
          push       = 1'b1;
          fetch_pc_d = fetch_pc_q + ADDR_LEN'(1);
          if (!(next_occ < (CNT_W+1)'(DEPTH))) state_d = IDLE;
        end
      end
      DISCARD: begin
        if (imem_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

  ifq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .pop        (deq_eff),
    .flush      (redirect),
    .push_entry (push_entry),
    .head_entry (head_entry),
    .count      (fifo_count)
  );

  assign imem_req    = (state_q != IDLE);
  assign imem_addr   = fetch_pc_q;
  assign valid       = fifo_valid;
  assign instruction = fifo_valid ? head_entry.instruction : '0;
  assign pc_plus1    = fifo_valid ? head_entry.pc_plus1 : '0;
  assign count       = fifo_count;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_instruction_fetch_queue.sv
`timescale 1ns/1ps
module tb_instruction_fetch_queue;
  import ifq_pkg::*;

  localparam int IL    = 19;
  localparam int AL    = 12;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          imem_req;
  logic [AL-1:0] imem_addr;
  logic          imem_ack = 1'b0;
  logic [IL-1:0] imem_data = '0;
  logic          redirect = 1'b0;
  logic [AL-1:0] redirect_pc = '0;
  logic          deq = 1'b0;
  logic          valid;
  logic [IL-1:0] instruction;
  logic [AL-1:0] pc_plus1;
  logic [CW-1:0] count;
  logic [1:0]    dbg_state;

  always #5 clk = ~clk;

  instruction_fetch_queue #(.INSTR_LEN(IL), .ADDR_LEN(AL), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_data(imem_data),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .deq(deq), .valid(valid), .instruction(instruction),
    .pc_plus1(pc_plus1), .count(count), .dbg_state(dbg_state)
  );

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- instruction memory (word = address) ----------------
  int mem_lat  = 0;   // extra wait cycles before ack
  int mem_wait = 0;

  function automatic logic [IL-1:0] rom(input logic [AL-1:0] a);
    return IL'(a);
  endfunction

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rst || !imem_req) begin
        mem_wait = 0;
        imem_ack = 1'b0;
      end else begin
        if (imem_ack) mem_wait = 0;  // previous request completed on this edge
        imem_ack  = (mem_wait >= mem_lat);
        imem_data = rom(imem_addr);
        mem_wait++;
      end
    end
  end

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [IL-1:0] instr;
    logic [AL-1:0] pcp1;
  } ent_t;

  ent_t          exp_q[$];
  bit            m_busy = 0;   // a request is outstanding
  bit            m_drop = 0;   // its data must be thrown away
  logic [AL-1:0] m_pc   = '0;

  task automatic model_step();
    int sz   = exp_q.size();
    bit took = m_busy && imem_ack;
    bit pop  = deq && (sz > 0) && !redirect;
    if (redirect) begin
      exp_q.delete();
      m_pc = redirect_pc;
      if (took) begin
        m_busy = 0;
        m_drop = 0;
      end else if (m_busy) begin
        m_drop = 1;
      end
    end else begin
      if (!m_busy) begin
        if (sz < DEPTH) m_busy = 1;
      end else if (took) begin
        if (m_drop) begin
          m_busy = 0;
          m_drop = 0;
        end else begin
          chk("no_enq_when_full", sz < DEPTH, 1);
          exp_q.push_back('{instr: imem_data, pcp1: AL'(m_pc + 1)});
          m_pc = AL'(m_pc + 1);
          if (sz + 1 - int'(pop) >= DEPTH) m_busy = 0;
        end
      end
      if (pop) void'(exp_q.pop_front());
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        exp_q.delete();
        m_busy = 0;
        m_drop = 0;
        m_pc   = '0;
      end else begin
        model_step();
      end
    end
  end

  // ---------------- scoreboard: compare every cycle ----------------
  initial begin
    wait (cmp_en);
    forever begin
      @(negedge clk);
      chk("imem_req", imem_req, m_busy);
      chk("imem_addr", imem_addr, m_pc);
      chk("valid", valid, exp_q.size() > 0);
      chk("count", count, exp_q.size());
      chk("instruction", instruction, (exp_q.size() > 0) ? exp_q[0].instr : '0);
      chk("pc_plus1", pc_plus1, (exp_q.size() > 0) ? exp_q[0].pcp1 : '0);
      chk("count_le_depth", count <= DEPTH, 1);
    end
  end

  // ---------------- driver helpers ----------------
  task automatic wait_valid(input string name);
    int n = 0;
    while (!valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk(name, n < 40, 1);
  endtask

  task automatic wait_count(input string name, input int target);
    int n = 0;
    while (count != CW'(target) && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk(name, n < 40, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus with literal expectations ----------------
  initial begin
    repeat (2) @(posedge clk);
    cmp_en = 1;
    @(posedge clk); #2;
    rst = 0;
    deq = 1;

    // reset values, then zero-wait streaming with deq held high
    @(negedge clk);
    chk("rst_valid", valid, 0);
    chk("rst_req", imem_req, 0);
    chk("rst_count", count, 0);
    chk("rst_instr", instruction, 0);
    chk("rst_pcp1", pc_plus1, 0);
    @(negedge clk);
    chk("first_req", imem_req, 1);
    chk("first_addr", imem_addr, 0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("stream_valid", valid, 1);
      chk("stream_pcp1", pc_plus1, k + 1);
      chk("stream_instr", instruction, k);
    end

    // fill with deq=0, then a single deq reopens fetch
    deq = 0;
    repeat (3) @(negedge clk);
    chk("full_count", count, 4);
    chk("full_req", imem_req, 0);
    @(negedge clk);
    chk("full_hold_req", imem_req, 0);
    deq = 1;
    @(negedge clk);
    deq = 0;
    chk("after_deq_count", count, 3);
    chk("after_deq_req", imem_req, 0);
    chk("after_deq_head", pc_plus1, 12'h007);
    @(negedge clk);
    chk("refetch_req", imem_req, 1);
    chk("refetch_addr", imem_addr, 12'h009);

    // redirect while the ack lands, then 3-cycle memory with a mid-wait redirect
    redirect = 1; redirect_pc = 12'h100; mem_lat = 2;
    @(negedge clk);
    redirect = 0;
    chk("redir_ack_count", count, 0);
    chk("redir_ack_req", imem_req, 0);
    @(negedge clk);
    chk("slow_addr", imem_addr, 12'h100);
    @(negedge clk);
    redirect = 1; redirect_pc = 12'h200;
    @(negedge clk);
    redirect = 0;
    chk("discard_state", dbg_state, DISCARD);
    chk("discard_addr", imem_addr, 12'h200);
    @(negedge clk);
    chk("discard_dropped_count", count, 0);
    chk("discard_idle_req", imem_req, 0);
    @(negedge clk);
    chk("post_discard_addr", imem_addr, 12'h200);
    chk("post_discard_req", imem_req, 1);
    wait_valid("post_discard_wait");
    chk("post_discard_pcp1", pc_plus1, 12'h201);
    chk("post_discard_instr", instruction, 19'h00200);

    // PC wrap-around from 0xFFE with zero-wait memory
    redirect = 1; redirect_pc = 12'hFFE; mem_lat = 0;
    @(negedge clk);
    redirect = 0;
    wait_valid("wrap_wait");
    chk("wrap_pcp1_0", pc_plus1, 12'hFFF);
    chk("wrap_instr_0", instruction, 19'h00FFE);
    deq = 1;
    @(negedge clk);
    chk("wrap_pcp1_1", pc_plus1, 12'h000);
    chk("wrap_instr_1", instruction, 19'h00FFF);
    @(negedge clk);
    chk("wrap_pcp1_2", pc_plus1, 12'h001);
    chk("wrap_instr_2", instruction, 19'h00000);

    // redirect + deq in the ack cycle with two entries queued
    deq = 0; redirect = 1; redirect_pc = 12'h040;
    @(negedge clk);
    redirect = 0;
    wait_count("fill_two", 2);
    chk("pre_redir_req", imem_req, 1);
    redirect = 1; redirect_pc = 12'h080; deq = 1;
    @(negedge clk);
    redirect = 0; deq = 0;
    chk("redir_deq_count", count, 0);
    chk("redir_deq_valid", valid, 0);
    chk("redir_deq_req", imem_req, 0);
    @(negedge clk);
    chk("redir_deq_addr", imem_addr, 12'h080);

    // asynchronous reset mid-request with three entries queued
    wait_count("fill_three", 3);
    chk("pre_rst_req", imem_req, 1);
    #1 rst = 1;
    #1;
    chk("arst_req", imem_req, 0);
    chk("arst_valid", valid, 0);
    chk("arst_count", count, 0);
    chk("arst_instr", instruction, 0);
    chk("arst_pcp1", pc_plus1, 0);
    chk("arst_addr", imem_addr, 0);
    #1 rst = 0;
    @(negedge clk);
    chk("restart_req", imem_req, 1);
    chk("restart_addr", imem_addr, 0);
    wait_valid("restart_wait");
    chk("restart_pcp1", pc_plus1, 12'h001);
    chk("restart_instr", instruction, 19'h00000);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
